// File: rtl/vdot_pkg.sv
`default_nettype none
// ============================================================================
// vdot_pkg
// Shared op codes, sequencer states and sizing for vector_dot_sequencer.
// Rev 1.0
// ============================================================================
package vdot_pkg;

  localparam int N_LANES = 8;
  localparam int RES_W   = 19;
  localparam int IDX_W   = $clog2(N_LANES);
  localparam int ADDR_W  = 6;

  localparam logic [1:0] OP_LOAD_W = 2'b00;
  localparam logic [1:0] OP_LOAD_A = 2'b01;
  localparam logic [1:0] OP_READ_S = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_A  = 3'd2,
    ST_READ    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_COLLECT = 3'd5,
    ST_HOLD    = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/result_deser.sv
`default_nettype none
// ============================================================================
// result_deser
// Captures the array's three serial result bytes (MSB first) READ_LAT cycles
// after the READ_S issue cycle and assembles the 19-bit dot product.
// Rev 1.0
// ============================================================================
module result_deser
  import vdot_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [7:0]       i_byte,
  output logic             o_done,
  output logic [RES_W-1:0] o_res_data,
  output logic             o_res_err
);

  localparam int POS_W = $clog2(READ_LAT + 3) + 1;
  localparam logic [POS_W-1:0] c_CAP_FIRST = POS_W'(READ_LAT);
  localparam logic [POS_W-1:0] c_CAP_LAST  = POS_W'(READ_LAT + 2);

  logic             r_active;
  logic [POS_W-1:0] r_pos;
  logic [15:0]      r_shift;
  logic [RES_W-1:0] r_res;
  logic             r_err;
  logic             w_cap;
  logic             w_last;

  // r_pos counts cycles since the issue cycle; READ_LAT must be at least 1.
  assign w_cap  = r_active && (r_pos >= c_CAP_FIRST);
  assign w_last = r_active && (r_pos == c_CAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_pos    <= '0;
      r_shift  <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (i_start) begin
        r_active <= 1'b1;
        r_pos    <= POS_W'(1);
      end else if (r_active) begin
        r_pos <= r_pos + POS_W'(1);
        if (w_last) begin
          r_active <= 1'b0;
        end
      end
      if (w_cap) begin
        r_shift <= {r_shift[7:0], i_byte};
      end
      // Upper five bits of byte2 can never be set by a legal sum.
      if (w_last) begin
        r_res <= {r_shift[10:8], r_shift[7:0], i_byte};
        r_err <= |r_shift[15:11];
      end
    end
  end

  assign o_done     = w_last;
  assign o_res_data = r_res;
  assign o_res_err  = r_err;

endmodule
`default_nettype wire

// File: rtl/vector_dot_sequencer.sv
`default_nettype none
// ============================================================================
// vector_dot_sequencer
// Streams weights/activations into the 8-lane compute-in-SRAM array, issues
// the read, and returns the 19-bit dot product on a valid/ready port.
// Rev 1.0
// ============================================================================
module vector_dot_sequencer
  import vdot_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             reuse_w,
  output logic [1:0]       arr_op,
  output logic [5:0]       arr_addr,
  output logic [7:0]       arr_data,
  input  logic [7:0]       arr_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             res_err
);

  seq_state_t        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_w_loaded;
  logic              r_in_ready;
  logic              r_res_valid;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;

  logic w_hs;
  logic w_last_idx;
  logic w_start;
  logic w_done;

  assign w_hs       = in_valid && r_in_ready;
  assign w_last_idx = (r_idx == IDX_W'(N_LANES - 1));
  assign w_start    = (r_op == OP_READ_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_w_loaded  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_op        <= OP_NOP;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_op <= OP_NOP;
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_hs) begin
            r_addr <= '0;
            r_data <= in_data;
            r_idx  <= IDX_W'(1);
            // reuse_w only matters on the first byte of a frame
            if (reuse_w && r_w_loaded) begin
              r_op    <= OP_LOAD_A;
              r_state <= ST_LOAD_A;
            end else begin
              r_op    <= OP_LOAD_W;
              r_state <= ST_LOAD_W;
            end
          end
        end

        ST_LOAD_W, ST_LOAD_A: begin
          if (w_hs) begin
            r_op   <= (r_state == ST_LOAD_W) ? OP_LOAD_W : OP_LOAD_A;
            r_addr <= ADDR_W'(r_idx);
            r_data <= in_data;
            if (w_last_idx) begin
              r_idx <= '0;
              if (r_state == ST_LOAD_W) begin
                r_w_loaded <= 1'b1;
                r_state    <= ST_LOAD_A;
              end else begin
                r_in_ready <= 1'b0;
                r_state    <= ST_READ;
              end
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end

        ST_READ: begin
          r_op    <= OP_READ_S;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          r_state <= ST_COLLECT;
        end

        ST_COLLECT: begin
          if (w_done) begin
            r_res_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  result_deser #(
    .READ_LAT (READ_LAT)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_byte     (arr_dout),
    .o_done     (w_done),
    .o_res_data (res_data),
    .o_res_err  (res_err)
  );

  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign arr_op    = r_op;
  assign arr_addr  = r_addr;
  assign arr_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_vector_dot_sequencer.sv
`default_nettype none
// ============================================================================
// tb_vector_dot_sequencer
// Sequencer wired to a behavioural dot-product array; directed frames.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vector_dot_sequencer;
  import vdot_pkg::*;

  typedef struct {
    int data;
    bit err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        reuse_w;
  logic [1:0]  arr_op;
  logic [5:0]  arr_addr;
  logic [7:0]  arr_data;
  logic [7:0]  arr_dout;
  logic        res_valid;
  logic        res_ready;
  logic [18:0] res_data;
  logic        res_err;

  vector_dot_sequencer #(.READ_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .reuse_w   (reuse_w),
    .arr_op    (arr_op),
    .arr_addr  (arr_addr),
    .arr_data  (arr_data),
    .arr_dout  (arr_dout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  // Array model: latches loads, answers READ_S with three bytes MSB first,
  // the first one visible two cycles after the READ_S cycle.
  logic [7:0] am_w [8];
  logic [7:0] am_a [8];
  logic [7:0] am_q [$];
  bit         err_inject;

  always @(posedge clk) begin
    int s;
    logic [7:0] b2;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        am_w[i] = 8'h00;
        am_a[i] = 8'h00;
      end
      am_q.delete();
      arr_dout <= 8'h00;
    end else begin
      if (am_q.size() > 0) arr_dout <= am_q.pop_front();
      else                 arr_dout <= 8'h00;
      if (arr_op == OP_LOAD_W && arr_addr < 6'd8) am_w[arr_addr[2:0]] = arr_data;
      if (arr_op == OP_LOAD_A && arr_addr < 6'd8) am_a[arr_addr[2:0]] = arr_data;
      if (arr_op == OP_READ_S) begin
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(am_w[i]) * int'(am_a[i]);
        b2 = 8'(s >> 16);
        if (err_inject) b2 = b2 | 8'h80;
        am_q.push_back(b2);
        am_q.push_back(8'(s >> 8));
        am_q.push_back(8'(s));
      end
    end
  end

  // Bench-side reference state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_bus [$];
  res_t        exp_res [$];
  logic [7:0]  m_w [8];
  bit          m_wl = 1'b0;
  logic [7:0]  fw [8];
  logic [7:0]  fa [8];

  int cyc = 0, n_lw = 0, n_la = 0, n_rd = 0, n_in_hs = 0, n_res_hs = 0, n_vcyc = 0;
  int t_in_hs = 0, t_res_hs = 0, f_t0 = 0;
  int s_lw, s_la, s_rd, s_hs, s_v;
  int last_res = 0;
  bit last_err = 1'b0;
  bit hs_prev = 1'b0, vld_prev = 1'b0, vhs_prev = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic compare_cycle();
    logic [15:0] e;
    res_t r;
    cyc++;
    if (rst) begin
      hs_prev  = 1'b0;
      vld_prev = 1'b0;
      vhs_prev = 1'b0;
      return;
    end
    if (hs_prev) begin
      if (exp_bus.size() == 0) chk(1'b0, "bus_unexpected_load", {arr_op, arr_addr, arr_data}, 0);
      else begin
        e = exp_bus.pop_front();
        chk({arr_op, arr_addr, arr_data} == e, "bus_load", {arr_op, arr_addr, arr_data}, e);
      end
    end else begin
      chk(arr_op == OP_NOP || arr_op == OP_READ_S, "bus_idle_op", arr_op, OP_NOP);
    end
    chk(arr_addr < 6'(N_LANES), "addr_range", arr_addr, N_LANES - 1);
    if (arr_op == OP_LOAD_W) n_lw++;
    if (arr_op == OP_LOAD_A) n_la++;
    if (arr_op == OP_READ_S) n_rd++;
    if (res_valid) begin
      n_vcyc++;
      chk(in_ready == 1'b0, "in_ready_during_hold", in_ready, 0);
      if (exp_res.size() == 0) chk(1'b0, "res_stale", res_data, 0);
      else begin
        r = exp_res[0];
        chk(longint'(res_data) == longint'(r.data), "res_data", res_data, r.data);
        chk(res_err == r.err, "res_err", res_err, r.err);
        if (res_ready) begin
          void'(exp_res.pop_front());
          last_res = int'(res_data);
          last_err = res_err;
          n_res_hs++;
          t_res_hs = cyc;
        end
      end
    end else if (vld_prev && !vhs_prev) begin
      chk(1'b0, "res_valid_dropped", 0, 1);
    end
    hs_prev = in_valid && in_ready;
    if (hs_prev) begin
      n_in_hs++;
      t_in_hs = cyc;
    end
    vld_prev = res_valid;
    vhs_prev = res_valid && res_ready;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit rw, input logic [1:0] op,
                           input int addr, input bit gaps);
    int cnt = 0;
    exp_bus.push_back({op, 6'(addr), d});
    in_valid = 1'b1;
    in_data  = d;
    reuse_w  = rw;
    @(negedge clk);
    while (!in_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) begin
      chk(1'b0, "in_ready_timeout", 0, 1);
      void'(exp_bus.pop_back());
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gaps && ($urandom_range(0, 9) < 3 || addr == 3)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit rw, input bit gaps, input int limit);
    bit full;
    int n = 0;
    int s = 0;
    full = !(rw && m_wl);
    if (full) begin
      for (int i = 0; i < 8; i++) begin
        if (n == limit) return;
        send_byte(fw[i], (n == 0) ? rw : !rw, OP_LOAD_W, i, gaps);
        if (n == 0) f_t0 = t_in_hs;
        m_w[i] = fw[i];
        n++;
      end
      m_wl = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      if (n == limit) return;
      send_byte(fa[i], (n == 0) ? rw : !rw, OP_LOAD_A, i, gaps);
      if (n == 0) f_t0 = t_in_hs;
      n++;
    end
    for (int i = 0; i < 8; i++) s += int'(m_w[i]) * int'(fa[i]);
    exp_res.push_back('{s, err_inject});
  endtask

  task automatic wait_result(input int hold);
    int r0 = n_res_hs;
    int cnt = 0;
    if (hold > 0) begin
      while (!res_valid && cnt < 300) begin
        @(negedge clk);
        cnt++;
      end
      repeat (hold) @(posedge clk);
      #1;
      res_ready = 1'b1;
    end
    while (n_res_hs == r0 && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    chk(n_res_hs != r0, "result_timeout", n_res_hs - r0, 1);
  endtask

  task automatic snap();
    s_lw = n_lw; s_la = n_la; s_rd = n_rd; s_hs = n_in_hs; s_v = n_vcyc;
  endtask

  task automatic check_reset_state(input string tag);
    chk(arr_op == OP_NOP, {tag, "_arr_op"}, arr_op, OP_NOP);
    chk(arr_addr == 6'd0 && arr_data == 8'd0, {tag, "_arr_addr_data"}, {arr_addr, arr_data}, 0);
    chk(in_ready == 1'b0, {tag, "_in_ready"}, in_ready, 0);
    chk(res_valid == 1'b0, {tag, "_res_valid"}, res_valid, 0);
    chk(res_data == 19'd0 && res_err == 1'b0, {tag, "_res_data_err"}, {res_err, res_data}, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reuse_w = 1'b0;
    res_ready = 1'b1; err_inject = 1'b0;
    fork
      begin : main_seq
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Full frame, w=a=1..8
        for (int i = 0; i < 8; i++) begin fw[i] = 8'(i + 1); fa[i] = 8'(i + 1); end
        snap(); send_frame(1'b0, 1'b0, 16); wait_result(0);
        chk(last_res == 204 && last_err == 1'b0, "t1_result", last_res, 204);
        chk(n_lw - s_lw == 8 && n_la - s_la == 8, "t1_load_counts", {n_lw - s_lw, n_la - s_la}, {8, 8});
        chk(n_rd - s_rd == 1, "t1_read_count", n_rd - s_rd, 1);
        chk(n_in_hs - s_hs == 16, "t1_bytes_accepted", n_in_hs - s_hs, 16);
        chk(n_vcyc - s_v == 1, "t1_valid_cycles", n_vcyc - s_v, 1);
        chk(t_res_hs - f_t0 == 22, "t1_frame_latency", t_res_hs - f_t0, 22);

        // Weight reuse, a=all 1
        for (int i = 0; i < 8; i++) fa[i] = 8'h01;
        snap(); send_frame(1'b1, 1'b0, 16); wait_result(0);
        chk(last_res == 36, "t3_result", last_res, 36);
        chk(n_lw - s_lw == 0, "t3_no_load_w", n_lw - s_lw, 0);
        chk(n_in_hs - s_hs == 8, "t3_bytes_accepted", n_in_hs - s_hs, 8);
        chk(t_res_hs - f_t0 == 14, "t3_frame_latency", t_res_hs - f_t0, 14);

        // Maximum operands
        for (int i = 0; i < 8; i++) begin fw[i] = 8'hFF; fa[i] = 8'hFF; end
        send_frame(1'b0, 1'b0, 16); wait_result(0);
        chk(last_res == 32'h7F008 && last_err == 1'b0, "t2_result", last_res, 32'h7F008);

        // Gapped input stream
        for (int i = 0; i < 8; i++) begin fw[i] = 8'(i + 1); fa[i] = 8'(i + 1); end
        snap(); send_frame(1'b0, 1'b1, 16); wait_result(0);
        chk(last_res == 204, "t4_result", last_res, 204);
        chk(n_lw - s_lw == 8 && n_la - s_la == 8, "t4_load_counts", {n_lw - s_lw, n_la - s_la}, {8, 8});

        // Result back-pressure for 5 cycles
        for (int i = 0; i < 8; i++) fa[i] = 8'(8 - i);
        res_ready = 1'b0;
        snap(); send_frame(1'b0, 1'b0, 16); wait_result(5);
        repeat (3) @(posedge clk);
        #1;
        chk(last_res == 120, "t5_result", last_res, 120);
        chk(n_vcyc - s_v == 6, "t5_valid_cycles", n_vcyc - s_v, 6);

        // Malformed byte2 from the array raises res_err
        for (int i = 0; i < 8; i++) fa[i] = 8'(i + 1);
        err_inject = 1'b1;
        send_frame(1'b1, 1'b0, 16); wait_result(0);
        err_inject = 1'b0;
        chk(last_res == 204 && last_err == 1'b1, "err_result", {last_err, 19'(last_res)}, {1'b1, 19'd204});

        // Reset mid-activation phase, then reuse request after reset
        for (int i = 0; i < 8; i++) fw[i] = 8'h03;
        send_frame(1'b0, 1'b0, 11);
        @(posedge clk); #1 rst = 1'b1;
        exp_bus.delete(); exp_res.delete(); m_wl = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) fw[i] = 8'h02;
        snap(); send_frame(1'b1, 1'b0, 16); wait_result(0);
        chk(last_res == 72, "t6_result", last_res, 72);
        chk(n_lw - s_lw == 8 && n_in_hs - s_hs == 16, "t6_full_load", {n_lw - s_lw, n_in_hs - s_hs}, {8, 16});
        repeat (5) @(posedge clk);
        #1;
        chk(exp_res.size() == 0 && exp_bus.size() == 0, "queues_drained", exp_res.size() + exp_bus.size(), 0);
      end
      forever begin
        @(negedge clk);
        compare_cycle();
      end
      begin
        #1000000;
        chk(1'b0, "global_timeout", 0, 1);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
